bcd_to_bin_seq: RTL
===================

Name: bcd_to_bin_seq

Overview:
Sequential BCD-to-binary converter, the inverse of the team's combinational binary-to-BCD block. It takes a packed 4-digit BCD value, for example from a decimal keypad or the FND entry path, and returns its binary value. It uses the reverse double-dabble method (shift right, then subtract 3 from any nibble that is 8 or more), one iteration per clock. It has a start/busy/done handshake so that one small datapath serves any caller without wide combinational logic.

Parameters:
DIGITS, 4, number of BCD digits in bcd_in (each digit is 4 bits).
BIN_W, 14, width of bin_out and the number of shift iterations; must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
clk  input  1  system clock, all logic on the rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  one-cycle request; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD operand, most significant digit in the MSBs; sampled on the accepted start edge only.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; bin_out and err are valid from this cycle onward.
err  output  1  high when the last accepted operand contained a nibble greater than 9.
bin_out  output  BIN_W  converted binary result, held until the next accepted start.

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. On reset: state=IDLE, busy=0, done=0, err=0, bin_out=0, iteration counter=0.
- Reset mid-conversion aborts immediately with the values above; the partial result is discarded.
- Internal shift register sr is 4*DIGITS+BIN_W bits wide, laid out as {bcd_part, bin_part}.
- States:
  - IDLE: on start=1, load sr={bcd_in, BIN_W'b0}, set cnt=0, clear err. Go to CHECK.
  - CHECK (1 cycle): if any digit of sr's bcd_part is greater than 9: err<=1, bin_out<=0, done<=1, go to IDLE. Otherwise go to SHIFT.
  - SHIFT: each cycle, shift sr right by 1 (0 into the MSB). Then, for every digit of the new bcd_part, if the digit is 8 or more, subtract 3 (per-digit, 4-bit, no borrow between digits). Increment cnt. When cnt==BIN_W-1 on this edge: bin_out<=bin_part of the adjusted value, done<=1, go to IDLE.
- done is registered; it is high for exactly one cycle and deasserts on the next edge.
- Latency for a valid operand: start sampled at edge E0, CHECK at E1, shifts at E2..E(BIN_W+1). done is high in the cycle after edge E(BIN_W+1). With defaults, that is edge E15.
- Latency for an invalid operand: done is high in the cycle after E1.
- start while busy=1 is ignored and not queued; bcd_in changes while busy have no effect.
- start may be accepted in the same cycle that done is high, because the state is already IDLE. This allows back-to-back conversions every BIN_W+2 cycles.
- Overflow cannot occur for valid operands given the BIN_W constraint. bin_out is zero-extended; the bcd_part is all zero after the final shift.

Decomposition:
- Package bcd_conv_pkg contains:
  - the state enum {IDLE, CHECK, SHIFT};
  - BCD_DIGIT_MAX=9;
  - DD_THRESH=8;
  - DD_ADJ=3.
- Sub-module bcd_digit_adjust: combinational, 4-bit in, 4-bit out, output = in-3 if in is 8 or more, else in. Instantiated DIGITS times through a generate loop.
- A separate bcd_digit_valid check is not needed; it is a single compare inline in CHECK.

Test Plan:
- Reset, then start with bcd_in=16'h9999 -> done high exactly 15 cycles after the start edge, bin_out=14'd9999 (0x270F), err=0.
- bcd_in=16'h1234 -> bin_out=14'd1234 (0x04D2); bcd_in=16'h0000 -> bin_out=0, done after 15 cycles.
- bcd_in=16'h0A00 -> done high in the cycle after E1, err=1, bin_out=0. A following valid start with 16'h0042 clears err and gives bin_out=42.
- start=1 again at cycles 3 and 8 of a conversion with bcd_in changed to 16'h5555 -> ignored; result is still from the first operand; only one done pulse.
- reset asserted at cycle 7 of a conversion -> next cycle busy=0, done=0, bin_out=0, err=0. A fresh start with 16'h0100 gives 100.
- Back-to-back: start held high continuously, all 10000 valid BCD values stepped on each done -> each bin_out equals the decimal value; a new conversion is accepted every 16 cycles.

Source files
------------

// File: rtl/bcd_conv_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [3:0] DD_THRESH     = 4'd8;
    localparam logic [3:0] DD_ADJ        = 4'd3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Reverse double-dabble correction for one BCD digit: subtract 3 when the digit is 8 or more.
module bcd_digit_adjust
    import bcd_conv_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= DD_THRESH) begin
            adjusted = digit - DD_ADJ;
        end
    end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential BCD-to-binary converter: one reverse double-dabble iteration per clock,
// with a start/busy/done handshake.
module bcd_to_bin_seq
    import bcd_conv_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [BIN_W-1:0]      bin_out
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic [SR_W-1:0]    sr_shift;
    logic [BCD_W-1:0]   adj_bcd;
    logic [SR_W-1:0]    sr_adj;
    logic               digit_bad;

    // sr is laid out as {bcd_part, bin_part}; the BCD digits drain into the binary part.
    assign sr_shift = {1'b0, sr_q[SR_W-1:1]};

    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit    (sr_shift[BIN_W + 4*d +: 4]),
            .adjusted (adj_bcd[4*d +: 4])
        );
    end

    assign sr_adj = {adj_bcd, sr_shift[BIN_W-1:0]};

    always_comb begin
        digit_bad = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (sr_q[BIN_W + 4*d +: 4] > BCD_DIGIT_MAX) begin
                digit_bad = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        err_d   = err_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {bcd_in, {BIN_W{1'b0}}};
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (digit_bad) begin
                    err_d   = 1'b1;
                    bin_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_adj;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bin_d   = sr_adj[BIN_W-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign bin_out = bin_q;

endmodule
